// File: rtl/spi_pkg.sv
// Shared SPI definitions for the byte master and the FPGA slave-side code.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } spi_m_state_t;

endpackage

// File: rtl/spi_master_byte_if.sv
// Byte stream (tx valid/ready in, rx pulse out) between a host and spi_master_byte.
interface spi_master_byte_if;
    import spi_pkg::*;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_last;
    logic                  rx_valid;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  busy;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, rx_valid, rx_data, busy
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK half-period timer: alternating rise/fall ticks every CLK_DIV clocks while run is high.
module spi_sck_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] half_cnt;
    logic          phase;
    logic          wrap;

    assign wrap      = run && (half_cnt == HALF_LAST);
    assign rise_tick = wrap && !phase;
    assign fall_tick = wrap && phase;

    // Dropping run rearms the timer so every byte starts with a full low half.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (wrap) begin
            half_cnt <= '0;
            phase    <= ~phase;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-0 master, MSB first, 8-bit frames; SSEL held low across a burst until tx_last.
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CS_IDLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_byte_if.slave   bus,
    output logic               SCK,
    output logic               SSEL,
    output logic               MOSI,
    input  logic               MISO
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_XFER = XFER;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_HOLD = HOLD;

    localparam int IW = $clog2(CS_IDLE + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(CS_IDLE - 1);

    logic [1:0]            state;
    logic [SPI_BYTE_W-2:0] tx_sh;
    logic [SPI_BYTE_W-1:0] rx_sh;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  last_q;
    logic [2:0]            bit_cnt;
    logic [IW-1:0]         idle_cnt;
    logic [1:0]            miso_pipe;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  accept;

    assign bus.tx_ready = !rst && (state == ST_IDLE || state == ST_WAIT);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign accept       = bus.tx_valid && bus.tx_ready;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (state == ST_XFER),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            SCK        <= 1'b0;
            SSEL       <= 1'b1;
            MOSI       <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            last_q     <= 1'b0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            miso_pipe  <= '0;
        end else begin
            miso_pipe  <= {miso_pipe[0], MISO};
            rx_valid_q <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (accept) begin
                        tx_sh   <= bus.tx_data[SPI_BYTE_W-2:0];
                        MOSI    <= bus.tx_data[SPI_BYTE_W-1];
                        last_q  <= bus.tx_last;
                        SSEL    <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (rise_tick) begin
                        SCK   <= 1'b1;
                        rx_sh <= {rx_sh[SPI_BYTE_W-2:0], miso_pipe[1]};
                    end
                    if (fall_tick) begin
                        SCK <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_data_q  <= rx_sh;
                            rx_valid_q <= 1'b1;
                            idle_cnt   <= '0;
                            state      <= last_q ? ST_HOLD : ST_WAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            MOSI    <= tx_sh[SPI_BYTE_W-2];
                            tx_sh   <= {tx_sh[SPI_BYTE_W-3:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    // SSEL rises one clock after the final SCK fall, then stays high CS_IDLE clocks.
                    SSEL <= 1'b1;
                    MOSI <= 1'b0;
                    if (idle_cnt == IDLE_LAST) state <= ST_IDLE;
                    else                       idle_cnt <= idle_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Randomized bench for spi_master_byte: transaction-level model plus per-cycle SPI/stream monitor.
module tb_spi_master_byte;
    import spi_pkg::*;

    localparam int DIV  = 4;
    localparam int CSI  = 4;
    localparam int DIV8 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_byte_if bus();
    spi_master_byte_if bus8();

    logic sck, ssel, mosi, miso;
    logic sck8, ssel8, mosi8, miso8;

    spi_master_byte #(.CLK_DIV(DIV), .CS_IDLE(CSI)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .SCK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
    );

    spi_master_byte #(.CLK_DIV(DIV8), .CS_IDLE(CSI)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave),
        .SCK(sck8), .SSEL(ssel8), .MOSI(mosi8), .MISO(miso8)
    );

    int checks = 0;
    int errors = 0;

    // transaction model
    bit          loopback = 1'b1;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    int          exp_len[$];
    logic [31:0] slave_q[$];
    logic [31:0] sw = '0;
    logic [7:0]  rx_log[$];

    // monitor state
    bit          mon_en = 1'b0;
    bit          fresh = 1'b1;
    logic        prev_sck = 1'b0, prev_ssel = 1'b1;
    int          hi_len = 0, lo_len = 0, ssel_lo_len = 0, ssel_hi_len = 0;
    int          since_fall = 0, nbits = 0, nbytes = 0;
    int          rises = 0, cs_rises = 0, rx_cnt = 0;
    int          last_lo = 0, min_hi = 1000;
    logic [7:0]  mbits = '0, last_mosi = '0;

    assign miso = loopback ? mosi : sw[31];

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk(name, act === req, act, req);
    endtask

    // Per-cycle compare process; also plays the ideal slave that returns queued responses.
    initial begin : monitor
        bit s_rise, s_fall, c_rise, c_fall;
        int nexp;
        forever begin
            @(negedge clk);
            s_rise = sck && !prev_sck;
            s_fall = !sck && prev_sck;
            c_rise = ssel && !prev_ssel;
            c_fall = !ssel && prev_ssel;
            if (s_rise) rises++;
            if (c_rise) cs_rises++;
            if (bus.rx_valid) rx_cnt++;
            if (mon_en) begin
                since_fall++;
                if (ssel) check("sck_low_while_deselected", sck, 1'b0);
                if (!ssel) check("busy_while_selected", bus.busy, 1'b1);
                if (!bus.busy) check("ready_in_idle", bus.tx_ready, 1'b1);
                if (bus.busy && ssel) check("ready_low_in_hold", bus.tx_ready, 1'b0);
                if (sck) check("ready_low_in_xfer", bus.tx_ready, 1'b0);
                if (c_fall) begin
                    if (!fresh) chk("cs_idle_gap", ssel_hi_len >= CSI, ssel_hi_len, CSI);
                    if (!fresh && ssel_hi_len < min_hi) min_hi = ssel_hi_len;
                    fresh = 1'b0;
                    nbits = 0; nbytes = 0; ssel_lo_len = 1; lo_len = 0;
                    chk("cs_fall_expected", slave_q.size() > 0, slave_q.size(), 1);
                    sw = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                end else if (c_rise) begin
                    nexp = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
                    check("cs_rise_byte_count", nbytes, nexp);
                    check("cs_rise_mid_byte", nbits, 0);
                    check("cs_rise_after_last_fall", since_fall, 1);
                    if (nbytes == 1) check("cs_low_len_single", ssel_lo_len, 16 * DIV + 1);
                    last_lo = ssel_lo_len;
                    ssel_hi_len = 1;
                end else if (ssel) begin
                    ssel_hi_len++;
                end else begin
                    ssel_lo_len++;
                end
                if (bus.rx_valid) begin
                    chk("rx_valid_on_last_fall", s_fall && nbits == 0 && nbytes > 0, s_fall, 1);
                    nexp = (exp_rx.size() > 0) ? int'(exp_rx.pop_front()) : -1;
                    check("rx_data", bus.rx_data, nexp);
                    rx_log.push_back(bus.rx_data);
                end
                if (s_rise) begin
                    if (nbits == 0 && nbytes > 0) chk("sck_inter_byte_gap", lo_len >= DIV, lo_len, DIV);
                    else                          check("sck_low_half", lo_len, DIV);
                    mbits = {mbits[6:0], mosi};
                    nbits++;
                    hi_len = 1;
                    if (nbits == 8) begin
                        nbits = 0;
                        nbytes++;
                        last_mosi = mbits;
                        nexp = (exp_tx.size() > 0) ? int'(exp_tx.pop_front()) : -1;
                        check("mosi_byte", mbits, nexp);
                    end
                end else if (s_fall) begin
                    check("sck_high_half", hi_len, DIV);
                    lo_len = 1;
                    since_fall = 0;
                    sw = sw << 1;
                end else if (sck) begin
                    hi_len++;
                end else begin
                    lo_len++;
                end
            end
            prev_sck  = sck;
            prev_ssel = ssel;
        end
    end

    // Slave on the CLK_DIV=8 master that 3-flop-synchronises SCK/SSEL to clk.
    logic [2:0] s8_sck, s8_ssel;
    logic [7:0] sh8, m8;
    assign miso8 = sh8[7];
    always @(posedge clk) begin
        if (rst) begin
            s8_sck  <= '0;
            s8_ssel <= '1;
            sh8     <= '0;
            m8      <= '0;
        end else begin
            s8_sck  <= {s8_sck[1:0], sck8};
            s8_ssel <= {s8_ssel[1:0], ssel8};
            if (s8_ssel[2] && !s8_ssel[1])  sh8 <= 8'h5A;
            else if (s8_sck[2] && !s8_sck[1]) sh8 <= {sh8[6:0], 1'b0};
            if (!s8_sck[2] && s8_sck[1]) m8 <= {m8[6:0], mosi8};
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        bus.tx_last  = last;
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("tx_ready_timeout", 1'b0, n, 0);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        bus.tx_last  = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 1'b0, n, 0);
    endtask

    task automatic set_mode(input bit lb);
        if (lb != loopback) begin
            wait_idle();
            loopback = lb;
        end
    endtask

    // n bytes taken MSB-first from w; the slave answers with r (or echoes MOSI in loopback).
    task automatic trans(input int n, input logic [31:0] w, input logic [31:0] r, input bit lb, input int max_stall);
        logic [7:0] d;
        set_mode(lb);
        exp_len.push_back(n);
        slave_q.push_back(lb ? 32'h0 : r);
        for (int i = 0; i < n; i++) begin
            d = 8'(w >> (24 - 8 * i));
            exp_tx.push_back(d);
            exp_rx.push_back(lb ? d : 8'(r >> (24 - 8 * i)));
            if (max_stall > 0) repeat ($urandom_range(0, max_stall)) @(negedge clk);
            send(d, i == n - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, r0, c0, rx0, hi, lo;
        bit gap_ok;
        rst = 1'b1;
        bus.tx_valid = 1'b0;  bus.tx_data = '0;  bus.tx_last = 1'b0;
        bus8.tx_valid = 1'b0; bus8.tx_data = '0; bus8.tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ssel", ssel, 1'b1);
        check("reset_sck", sck, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_tx_ready", bus.tx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus.tx_ready, 1'b1);
        mon_en = 1'b1;

        // single byte loopback
        rx_log.delete();
        r0 = rises;
        trans(1, 32'hA500_0000, 32'h0, 1'b1, 0);
        wait_idle();
        check("t1_mosi_bits", last_mosi, 8'hA5);
        check("t1_sck_rises", rises - r0, 8);
        check("t1_rx_count", rx_log.size(), 1);
        check("t1_rx", rx_log[0], 8'hA5);
        check("t1_ssel_low_clks", last_lo, 65);

        // two-byte burst against a responding slave
        rx_log.delete();
        c0 = cs_rises;
        trans(2, 32'h0300_0000, 32'hFF04_0000, 1'b0, 0);
        wait_idle();
        check("t2_cs_rises", cs_rises - c0, 1);
        check("t2_rx_count", rx_log.size(), 2);
        check("t2_rx0", rx_log[0], 8'hFF);
        check("t2_rx1", rx_log[1], 8'h04);

        // stall between bytes of one transaction
        set_mode(1'b1);
        rx_log.delete();
        c0 = cs_rises;
        exp_len.push_back(2);
        slave_q.push_back(32'h0);
        exp_tx.push_back(8'h11); exp_rx.push_back(8'h11);
        exp_tx.push_back(8'h22); exp_rx.push_back(8'h22);
        send(8'h11, 1'b0);
        n = 0;
        while (rx_log.size() == 0 && n < 500) begin @(negedge clk); n++; end
        chk("t3_first_byte_timeout", n < 500, n, 500);
        gap_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (sck || ssel) gap_ok = 1'b0;
        end
        check("t3_gap_sel_low_sck_low", gap_ok, 1'b1);
        send(8'h22, 1'b1);
        wait_idle();
        check("t3_cs_rises", cs_rises - c0, 1);
        check("t3_rx_count", rx_log.size(), 2);
        check("t3_rx0", rx_log[0], 8'h11);
        check("t3_rx1", rx_log[1], 8'h22);

        // back-to-back single-byte transactions
        min_hi = 1000;
        for (int i = 0; i < 3; i++) trans(1, $urandom, 32'h0, 1'b1, 0);
        wait_idle();
        check("t4_min_ssel_high", min_hi, CSI);

        // reset in the middle of bit 4
        mon_en = 1'b0;
        r0 = rises;
        send(8'hF0, 1'b1);
        rx0 = rx_cnt;
        n = 0;
        while (rises - r0 < 5 && n < 1000) begin @(negedge clk); n++; end
        chk("t5_bit4_timeout", n < 1000, n, 1000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ssel", ssel, 1'b1);
        check("t5_sck", sck, 1'b0);
        check("t5_mosi", mosi, 1'b0);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_ready_in_reset", bus.tx_ready, 1'b0);
        check("t5_rx_data_cleared", bus.rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("t5_no_rx_valid", rx_cnt - rx0, 0);
        fresh = 1'b1;
        mon_en = 1'b1;
        rx_log.delete();
        trans(1, 32'h0F00_0000, 32'h0, 1'b1, 0);
        wait_idle();
        check("t5_rx_count", rx_log.size(), 1);
        check("t5_rx_after_reset", rx_log[0], 8'h0F);

        // randomized traffic
        for (int t = 0; t < 30; t++)
            trans($urandom_range(1, 3), $urandom, $urandom, 1'($urandom_range(0, 1)), 12);
        wait_idle();
        check("queue_tx_drained", exp_tx.size(), 0);
        check("queue_rx_drained", exp_rx.size(), 0);
        check("queue_len_drained", exp_len.size(), 0);

        // CLK_DIV=8 against a 3-flop-synchronising slave
        @(negedge clk);
        bus8.tx_valid = 1'b1; bus8.tx_data = 8'hC3; bus8.tx_last = 1'b1;
        n = 0;
        while (!bus8.tx_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        bus8.tx_valid = 1'b0;
        n = 0;
        while (!sck8 && n < 100) begin @(negedge clk); n++; end
        chk("t6_first_rise_timeout", n < 100, n, 100);
        hi = 0;
        while (sck8 && hi < 100) begin hi++; @(negedge clk); end
        lo = 0;
        while (!sck8 && lo < 100) begin lo++; @(negedge clk); end
        check("t6_sck_high_clks", hi, DIV8);
        check("t6_sck_low_clks", lo, DIV8);
        n = 0;
        while (!bus8.rx_valid && n < 500) begin @(negedge clk); n++; end
        chk("t6_rx_timeout", n < 500, n, 500);
        check("t6_rx_data", bus8.rx_data, 8'h5A);
        n = 0;
        while (bus8.busy && n < 100) begin @(negedge clk); n++; end
        check("t6_slave_saw_mosi", m8, 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
